// File: rtl/cam_capture_if.sv
// Camera capture bus: sensor pins, CPU control pulses, FIFO read port and status.
// The sensor/CPU side drives through 'master'; the capture block sits on 'slave'.
// The parameters must match those of the cam_capture instance attached to it.
interface cam_capture_if #(
  parameter int DATA_W     = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int X_W        = 10,
  parameter int Y_W        = 9
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              href;
  logic              vsync;
  logic [DATA_W-1:0] din;
  logic              start;
  logic              abort;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [LW-1:0]     level;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [X_W-1:0]    line_len;
  logic [Y_W-1:0]    line_cnt;

  modport master (
    output href, vsync, din, start, abort, rd_en,
    input  rd_data, empty, full, level, busy, done, overflow, line_len, line_cnt
  );

  modport slave (
    input  href, vsync, din, start, abort, rd_en,
    output rd_data, empty, full, level, busy, done, overflow, line_len, line_cnt
  );
endinterface

// File: rtl/cam_capture.sv
// Camera front end: synchronises href/vsync/din, captures one whole frame per
// arm request into a small first-word-fall-through FIFO, and reports line
// geometry plus done/overflow status. The FIFO head is held in a register so
// rd_data is a flop output; pin-to-rd_data latency is three clocks.
module cam_capture #(
  parameter int DATA_W     = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int DEC        = 1
) (
  input logic          clk,
  input logic          rst,
  cam_capture_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [3:0]    DEC_LAST = 4'(DEC - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        href_sync_q, href_sync_d;   // [1] = synced, [2] = edge-detect copy
  logic [2:0]        vsync_sync_q, vsync_sync_d;
  logic [DATA_W-1:0] din_s1_q, din_s1_d, din_s2_q, din_s2_d;
  logic              done_q, done_d, overflow_q, overflow_d;
  logic [X_W-1:0]    line_len_q, line_len_d, x_q, x_d;
  logic [Y_W-1:0]    line_cnt_q, line_cnt_d;
  logic [3:0]        dec_q, dec_d;
  logic [LW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              push_req, push_ok, pop;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic href_s, href_fall, vsync_fall, vsync_rise;
  assign href_s     = href_sync_q[1];
  assign href_fall  = href_sync_q[2] & ~href_sync_q[1];
  assign vsync_fall = vsync_sync_q[2] & ~vsync_sync_q[1];
  assign vsync_rise = ~vsync_sync_q[2] & vsync_sync_q[1];
  assign rd_next    = rd_ptr_q + 1'b1;

  // Next-state logic: sync chains, capture FSM, line counters and FIFO bookkeeping
  always_comb begin
    href_sync_d  = {href_sync_q[1:0], bus.href};
    vsync_sync_d = {vsync_sync_q[1:0], bus.vsync};
    din_s1_d     = bus.din;
    din_s2_d     = din_s1_q;
    state_d      = state_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    line_len_d   = line_len_q;
    line_cnt_d   = line_cnt_q;
    x_d          = x_q;
    dec_d        = dec_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_data_d    = rd_data_q;
    push_req     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = ARMED;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          line_len_d = '0;
          line_cnt_d = '0;
          x_d        = '0;
          dec_d      = '0;
        end
      end
      // Wait for the start of a fresh frame so nothing is captured mid-frame
      ARMED: if (vsync_fall) state_d = CAPTURE;
      CAPTURE: begin
        if (href_fall) begin
          line_len_d = x_q;
          if (~&line_cnt_q) line_cnt_d = line_cnt_q + 1'b1;
          x_d   = '0;
          dec_d = '0;
        end
        // A line still open at frame end is not counted; its pixels stay queued
        if (vsync_rise) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (href_s) begin
          push_req = (dec_q == 4'd0);
          if (push_req && ~&x_q) x_d = x_q + 1'b1;
          dec_d = (dec_q == DEC_LAST) ? 4'd0 : dec_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts a push when a pop frees a slot the same cycle
    pop     = bus.rd_en && (count_q != '0);
    push_ok = push_req && ((count_q != DEPTH_L) || pop);
    if (push_req && !push_ok) overflow_d = 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_next;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Keep the registered head equal to the oldest entry
    if (pop) begin
      if (count_q > LW'(1))  rd_data_d = mem_q[rd_next];
      else if (push_ok)      rd_data_d = din_s2_q;
    end else if ((count_q == '0) && push_ok) begin
      rd_data_d = din_s2_q;
    end

    if (bus.abort) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      overflow_d = 1'b0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_data_d  = '0;
      push_ok    = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_L);
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      href_sync_q  <= '0;
      vsync_sync_q <= '0;
      din_s1_q     <= '0;
      din_s2_q     <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      line_len_q   <= '0;
      line_cnt_q   <= '0;
      x_q          <= '0;
      dec_q        <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_data_q    <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      href_sync_q  <= href_sync_d;
      vsync_sync_q <= vsync_sync_d;
      din_s1_q     <= din_s1_d;
      din_s2_q     <= din_s2_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      line_len_q   <= line_len_d;
      line_cnt_q   <= line_cnt_d;
      x_q          <= x_d;
      dec_q        <= dec_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_data_q    <= rd_data_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_s2_q;
  end

  assign bus.busy     = (state_q == ARMED) || (state_q == CAPTURE);
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.line_len = line_len_q;
  assign bus.line_cnt = line_cnt_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.level    = count_q;
endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: two instances (DEC=1 and DEC=2) share one
// stimulus; inputs change on the falling edge, outputs are checked there too.
module tb_cam_capture;
  logic       clk = 1'b0;
  logic       rst;
  logic       href, vsync, start, abort, rd_en;
  logic [5:0] din;
  int         total  = 0;
  int         passed = 0;

  cam_capture_if #(.DATA_W(6), .FIFO_DEPTH(16), .X_W(10), .Y_W(9)) ifa ();
  cam_capture_if #(.DATA_W(6), .FIFO_DEPTH(16), .X_W(10), .Y_W(9)) ifb ();

  assign ifa.href = href;  assign ifa.vsync = vsync; assign ifa.din = din;
  assign ifa.start = start; assign ifa.abort = abort; assign ifa.rd_en = rd_en;
  assign ifb.href = href;  assign ifb.vsync = vsync; assign ifb.din = din;
  assign ifb.start = start; assign ifb.abort = abort; assign ifb.rd_en = rd_en;

  cam_capture #(.DATA_W(6), .FIFO_DEPTH(16), .X_W(10), .Y_W(9), .DEC(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  cam_capture #(.DATA_W(6), .FIFO_DEPTH(16), .X_W(10), .Y_W(9), .DEC(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(1); abort = 1'b0;
  endtask

  task automatic frame_begin();
    vsync = 1'b0; tick(4);
  endtask

  task automatic frame_end();
    vsync = 1'b1; tick(6);
  endtask

  task automatic send_line(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      href = 1'b1; din = 6'(base + i); tick(1);
    end
    href = 1'b0; tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; href = 1'b0; vsync = 1'b1; din = '0;
    start = 1'b0; abort = 1'b0; rd_en = 1'b0;
    tick(3); rst = 1'b0; tick(3);
    total++; if (ifa.empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", ifa.empty); else passed++;
    total++; if (ifa.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", ifa.full); else passed++;
    total++; if (ifa.level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", ifa.level); else passed++;
    total++; if (ifa.rd_data !== 6'd0) $display("FAIL reset_rd_data: got %0d expected 0", ifa.rd_data); else passed++;
    total++; if ({ifa.busy, ifa.done, ifa.overflow} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {ifa.busy, ifa.done, ifa.overflow}); else passed++;
    total++; if ({ifa.line_len, ifa.line_cnt} !== 19'd0) $display("FAIL reset_lines: got %0d/%0d expected 0/0", ifa.line_len, ifa.line_cnt); else passed++;
  endtask

  task automatic test_basic_frame();
    logic [5:0] exp_px [8] = '{6'd7, 6'd9, 6'd5, 6'd3, 6'd1, 6'd2, 6'd3, 6'd4};
    pulse_start();
    total++; if (ifa.busy !== 1'b1) $display("FAIL basic_busy_armed: got %b expected 1", ifa.busy); else passed++;
    frame_begin();
    href = 1'b1; din = 6'd7; tick(1);
    din = 6'd9; tick(1);
    din = 6'd5;
    total++; if (ifa.empty !== 1'b1) $display("FAIL basic_latency_early: empty got %b expected 1", ifa.empty); else passed++;
    tick(1);
    din = 6'd3;
    total++; if (ifa.empty !== 1'b0) $display("FAIL basic_latency_empty: got %b expected 0", ifa.empty); else passed++;
    total++; if (ifa.rd_data !== 6'd7) $display("FAIL basic_latency_data: got %0d expected 7", ifa.rd_data); else passed++;
    tick(1); href = 1'b0; tick(3);
    send_line(1, 4);
    frame_end();
    total++; if (ifa.done !== 1'b1) $display("FAIL basic_done: got %b expected 1", ifa.done); else passed++;
    total++; if (ifa.busy !== 1'b0) $display("FAIL basic_busy_done: got %b expected 0", ifa.busy); else passed++;
    total++; if (ifa.line_cnt !== 9'd2) $display("FAIL basic_line_cnt: got %0d expected 2", ifa.line_cnt); else passed++;
    total++; if (ifa.line_len !== 10'd4) $display("FAIL basic_line_len: got %0d expected 4", ifa.line_len); else passed++;
    total++; if (ifa.level !== 5'd8) $display("FAIL basic_level: got %0d expected 8", ifa.level); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (ifa.rd_data !== exp_px[i]) $display("FAIL basic_pop%0d: got %0d expected %0d", i, ifa.rd_data, exp_px[i]); else passed++;
      rd_en = 1'b1; tick(1);
    end
    rd_en = 1'b0;
    total++; if (ifa.empty !== 1'b1) $display("FAIL basic_drained_empty: got %b expected 1", ifa.empty); else passed++;
    rd_en = 1'b1; tick(3); rd_en = 1'b0;
    total++; if (ifa.level !== 5'd0) $display("FAIL underflow_level: got %0d expected 0", ifa.level); else passed++;
    total++; if (ifa.empty !== 1'b1) $display("FAIL underflow_empty: got %b expected 1", ifa.empty); else passed++;
  endtask

  task automatic test_arm_mid_frame();
    frame_begin();
    send_line(20, 3);
    pulse_start();
    send_line(30, 3);
    send_line(40, 2);
    total++; if (ifa.level !== 5'd0) $display("FAIL midframe_level: got %0d expected 0", ifa.level); else passed++;
    total++; if (ifa.busy !== 1'b1) $display("FAIL midframe_busy: got %b expected 1", ifa.busy); else passed++;
    frame_end();
    total++; if (ifa.busy !== 1'b1) $display("FAIL midframe_busy_blank: got %b expected 1", ifa.busy); else passed++;
    total++; if (ifa.done !== 1'b0) $display("FAIL midframe_done_cleared: got %b expected 0", ifa.done); else passed++;
    frame_begin();
    send_line(11, 2);
    frame_end();
    total++; if (ifa.level !== 5'd2) $display("FAIL midframe_next_level: got %0d expected 2", ifa.level); else passed++;
    total++; if (ifa.line_cnt !== 9'd1) $display("FAIL midframe_line_cnt: got %0d expected 1", ifa.line_cnt); else passed++;
    total++; if (ifa.rd_data !== 6'd11) $display("FAIL midframe_head: got %0d expected 11", ifa.rd_data); else passed++;
    rd_en = 1'b1; tick(1);
    total++; if (ifa.rd_data !== 6'd12) $display("FAIL midframe_second: got %0d expected 12", ifa.rd_data); else passed++;
    tick(1); rd_en = 1'b0;
    total++; if (ifa.empty !== 1'b1) $display("FAIL midframe_empty: got %b expected 1", ifa.empty); else passed++;
  endtask

  task automatic test_overflow();
    pulse_start();
    frame_begin();
    send_line(1, 20);
    frame_end();
    total++; if (ifa.level !== 5'd16) $display("FAIL ovf_level: got %0d expected 16", ifa.level); else passed++;
    total++; if (ifa.full !== 1'b1) $display("FAIL ovf_full: got %b expected 1", ifa.full); else passed++;
    total++; if (ifa.overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", ifa.overflow); else passed++;
    total++; if (ifa.line_len !== 10'd20) $display("FAIL ovf_line_len: got %0d expected 20", ifa.line_len); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++; if (ifa.rd_data !== 6'(i + 1)) $display("FAIL ovf_pop%0d: got %0d expected %0d", i, ifa.rd_data, i + 1); else passed++;
      rd_en = 1'b1; tick(1);
    end
    total++; if (ifa.empty !== 1'b1) $display("FAIL ovf_drained: got %b expected 1", ifa.empty); else passed++;
    pulse_start();
    total++; if (ifa.overflow !== 1'b0) $display("FAIL ovf_cleared_by_start: got %b expected 0", ifa.overflow); else passed++;
    frame_begin();
    send_line(1, 20);
    frame_end();
    rd_en = 1'b0;
    total++; if (ifa.overflow !== 1'b0) $display("FAIL ovf_with_reads: got %b expected 0", ifa.overflow); else passed++;
    total++; if (ifa.done !== 1'b1) $display("FAIL ovf_reads_done: got %b expected 1", ifa.done); else passed++;
    total++; if (ifa.empty !== 1'b1) $display("FAIL ovf_reads_empty: got %b expected 1", ifa.empty); else passed++;
  endtask

  task automatic test_decimation();
    logic [5:0] exp_px [4] = '{6'd0, 6'd2, 6'd4, 6'd6};
    pulse_abort();
    total++; if (ifb.empty !== 1'b1) $display("FAIL dec_flushed: got %b expected 1", ifb.empty); else passed++;
    pulse_start();
    frame_begin();
    send_line(0, 8);
    frame_end();
    total++; if (ifb.level !== 5'd4) $display("FAIL dec_level: got %0d expected 4", ifb.level); else passed++;
    total++; if (ifb.line_len !== 10'd4) $display("FAIL dec_line_len: got %0d expected 4", ifb.line_len); else passed++;
    total++; if (ifa.line_len !== 10'd8) $display("FAIL dec1_line_len: got %0d expected 8", ifa.line_len); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (ifb.rd_data !== exp_px[i]) $display("FAIL dec_pop%0d: got %0d expected %0d", i, ifb.rd_data, exp_px[i]); else passed++;
      rd_en = 1'b1; tick(1);
    end
    rd_en = 1'b0;
    total++; if (ifb.empty !== 1'b1) $display("FAIL dec_empty: got %b expected 1", ifb.empty); else passed++;
  endtask

  task automatic test_abort();
    pulse_start();
    frame_begin();
    href = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 6'(50 + i); tick(1);
    end
    total++; if (ifa.empty !== 1'b0) $display("FAIL abort_precond: empty got %b expected 0", ifa.empty); else passed++;
    pulse_abort();
    href = 1'b0;
    total++; if (ifa.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", ifa.busy); else passed++;
    total++; if (ifa.empty !== 1'b1) $display("FAIL abort_empty: got %b expected 1", ifa.empty); else passed++;
    total++; if (ifa.level !== 5'd0) $display("FAIL abort_level: got %0d expected 0", ifa.level); else passed++;
    total++; if (ifa.done !== 1'b0) $display("FAIL abort_done: got %b expected 0", ifa.done); else passed++;
    tick(3);
    frame_end();
    start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    total++; if (ifa.busy !== 1'b0) $display("FAIL start_abort_busy: got %b expected 0", ifa.busy); else passed++;
    tick(2);
    total++; if (ifa.busy !== 1'b0) $display("FAIL start_abort_stay_idle: got %b expected 0", ifa.busy); else passed++;
  endtask

  task automatic test_vsync_during_line();
    pulse_start();
    frame_begin();
    send_line(1, 3);
    href = 1'b1; din = 6'd10; tick(1);
    din = 6'd11; tick(1);
    vsync = 1'b1; din = 6'd12; tick(1);
    din = 6'd13; tick(2);
    href = 1'b0; tick(4);
    total++; if (ifa.done !== 1'b1) $display("FAIL partial_done: got %b expected 1", ifa.done); else passed++;
    total++; if (ifa.line_cnt !== 9'd1) $display("FAIL partial_line_cnt: got %0d expected 1", ifa.line_cnt); else passed++;
    total++; if (ifa.line_len !== 10'd3) $display("FAIL partial_line_len: got %0d expected 3", ifa.line_len); else passed++;
  endtask

  task automatic test_async_reset();
    pulse_start();
    frame_begin();
    send_line(5, 3);
    href = 1'b1; din = 6'd9; tick(2);
    total++; if (ifa.line_cnt !== 9'd1) $display("FAIL areset_precond: line_cnt got %0d expected 1", ifa.line_cnt); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (ifa.busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", ifa.busy); else passed++;
    total++; if (ifa.empty !== 1'b1) $display("FAIL areset_empty: got %b expected 1", ifa.empty); else passed++;
    total++; if (ifa.level !== 5'd0) $display("FAIL areset_level: got %0d expected 0", ifa.level); else passed++;
    total++; if (ifa.rd_data !== 6'd0) $display("FAIL areset_rd_data: got %0d expected 0", ifa.rd_data); else passed++;
    total++; if (ifa.line_cnt !== 9'd0) $display("FAIL areset_line_cnt: got %0d expected 0", ifa.line_cnt); else passed++;
    total++; if (ifa.line_len !== 10'd0) $display("FAIL areset_line_len: got %0d expected 0", ifa.line_len); else passed++;
    href = 1'b0; vsync = 1'b1;
    tick(2); rst = 1'b0; tick(2);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_arm_mid_frame();
    test_overflow();
    test_decimation();
    test_abort();
    test_vsync_during_line();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
